multiply_dispatcher: RTL and testbench



---
 rtl/multiply_dispatcher.sv | 110 +++++++++++
 tb/tb_multiply_dispatcher.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_dispatcher.sv
// Operand FIFO + Start/Done sequencer in front of the 8x8 shift-add multiplier.
// Products come back on a registered valid/ready stream.
module multiply_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [7:0]               In_A,
  input  logic [7:0]               In_B,
  output logic                     Mul_Start,
  output logic [7:0]               Mul_Multiplicand,
  output logic [7:0]               Mul_Multiplier,
  input  logic [15:0]              Mul_Product,
  input  logic                     Mul_Done,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [15:0]              Out_Product,
  output logic [$clog2(DEPTH):0]   Fill,
  output logic                     Busy
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  state_t                   r_state, w_next;
  logic [DEPTH-1:0][15:0]   r_mem;
  logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [PW:0]              r_fill;
  logic [7:0]               r_op_a, r_op_b;
  logic                     r_out_valid;
  logic [15:0]              r_out_product;
  logic                     w_push, w_pop, w_capture;

  assign In_Ready  = (r_fill != (PW+1)'(DEPTH));
  assign w_push    = In_Valid && In_Ready;
  // Occupancy is registered, so an entry pushed this cycle is not visible to pop.
  assign w_pop     = (r_state == S_IDLE) && (r_fill != '0) && !Mul_Done;
  assign w_capture = (r_state == S_ISSUE) && Mul_Done && (!r_out_valid || Out_Ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pop)     w_next = S_ISSUE;
      S_ISSUE:   if (w_capture) w_next = S_RELEASE;
      S_RELEASE: if (!Mul_Done) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {In_A, In_B};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (PW+1)'(1);
        2'b01:   r_fill <= r_fill - (PW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_pop) begin
      r_op_a <= r_mem[r_rd_ptr][15:8];
      r_op_b <= r_mem[r_rd_ptr][7:0];
    end
  end

  // A capture wins over a same-cycle consume, so back-to-back products stream.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else if (w_capture) begin
      r_out_valid   <= 1'b1;
      r_out_product <= Mul_Product;
    end else if (Out_Ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign Mul_Start        = (r_state == S_ISSUE);
  assign Mul_Multiplicand = r_op_a;
  assign Mul_Multiplier   = r_op_b;
  assign Out_Valid        = r_out_valid;
  assign Out_Product      = r_out_product;
  assign Fill             = r_fill;
  assign Busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_multiply_dispatcher.sv
// Scoreboard bench for multiply_dispatcher with a behavioural 10-cycle multiplier.
module tb_multiply_dispatcher;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  In_A, In_B;
  logic        Mul_Start;
  logic [7:0]  Mul_Multiplicand, Mul_Multiplier;
  logic [15:0] Mul_Product;
  logic        Mul_Done;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Product;
  logic [2:0]  Fill;
  logic        Busy;

  logic        m_done = 1'b0;
  logic [3:0]  m_cnt = '0;
  logic [15:0] m_prod = '0;
  logic        force_done;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [15:0] exp_q[$];

  always #5 Clock = ~Clock;

  multiply_dispatcher #(.DEPTH(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_A(In_A), .In_B(In_B),
    .Mul_Start(Mul_Start), .Mul_Multiplicand(Mul_Multiplicand),
    .Mul_Multiplier(Mul_Multiplier), .Mul_Product(Mul_Product), .Mul_Done(Mul_Done),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Product(Out_Product),
    .Fill(Fill), .Busy(Busy)
  );

  // Multiplier: Done rises 10 edges after Start, held while Start stays high.
  always @(posedge Clock) begin
    if (!Mul_Start) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (!m_done) begin
      if (m_cnt == 4'd9) begin
        m_done <= 1'b1;
        m_prod <= Mul_Multiplicand * Mul_Multiplier;
      end else begin
        m_cnt <= m_cnt + 4'd1;
      end
    end
  end

  assign Mul_Done    = m_done | force_done;
  assign Mul_Product = m_prod;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic        prev_start;
    logic [15:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset_n) begin
        if (Out_Valid && Out_Ready) begin
          n_out++;
          if (exp_q.size() == 0) chk("unexpected_product", 32'(Out_Product), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("product", 32'(Out_Product), 32'(e));
          end
        end
        if (Mul_Start && !prev_start) chk("start_while_done", 32'(Mul_Done), 0);
      end
      prev_start = Mul_Start;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    logic acc;
    acc = 1'b0;
    In_A = a; In_B = b; In_Valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge Clock);
      acc = In_Ready;
      @(posedge Clock); #1;
    end
    In_Valid = 1'b0;
    if (acc) exp_q.push_back(p);
    else chk("push_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge Clock);
      ok = (exp_q.size() == 0) && !Busy && (Fill == 3'd0) && !Out_Valid;
    end
    chk("drain", 32'(ok), 1);
    @(posedge Clock); #1;
  endtask

  task automatic wait_out_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge Clock);
      ok = Out_Valid;
    end
    chk("out_valid_timeout", 32'(ok), 1);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;
  vec_t wrap_v[12] = '{
    '{8'd1, 8'd1, 16'd1},     '{8'd2, 8'd2, 16'd4},     '{8'd3, 8'd3, 16'd9},
    '{8'd4, 8'd4, 16'd16},    '{8'd5, 8'd5, 16'd25},    '{8'd10, 8'd10, 16'd100},
    '{8'd20, 8'd3, 16'd60},   '{8'd100, 8'd2, 16'd200}, '{8'd255, 8'd1, 16'd255},
    '{8'd128, 8'd2, 16'd256}, '{8'd15, 8'd15, 16'd225}, '{8'd200, 8'd200, 16'd40000}
  };

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    Reset_n = 1'b0; In_Valid = 1'b0; In_A = '0; In_B = '0;
    Out_Ready = 1'b1; force_done = 1'b0;
    #2;
    chk("rst_start", 32'(Mul_Start), 0);
    chk("rst_out_valid", 32'(Out_Valid), 0);
    chk("rst_out_product", 32'(Out_Product), 0);
    chk("rst_fill", 32'(Fill), 0);
    chk("rst_in_ready", 32'(In_Ready), 1);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_operands", 32'({Mul_Multiplicand, Mul_Multiplier}), 0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    repeat (2) begin @(posedge Clock); #1; end

    // Single op
    base = n_out;
    push(8'd12, 8'd11, 16'd132);
    wait_out_valid();
    chk("start_low_at_capture", 32'(Mul_Start), 0);
    chk("single_product", 32'(Out_Product), 132);
    @(negedge Clock);
    chk("single_pulse", 32'(Out_Valid), 0);
    wait_drain();
    chk("single_count", 32'(n_out - base), 1);

    // Burst of 4 held off by Done so the FIFO fills
    force_done = 1'b1;
    push(8'd255, 8'd255, 16'd65025);
    push(8'd0, 8'd77, 16'd0);
    push(8'd1, 8'd200, 16'd200);
    push(8'd16, 8'd16, 16'd256);
    chk("full_fill", 32'(Fill), 4);
    chk("full_in_ready", 32'(In_Ready), 0);
    In_A = 8'd9; In_B = 8'd9; In_Valid = 1'b1;
    repeat (2) begin @(posedge Clock); #1; end
    In_Valid = 1'b0;
    chk("full_ignored", 32'(Fill), 4);
    chk("stale_no_issue", 32'(Mul_Start), 0);
    force_done = 1'b0;
    wait_drain();

    // Simultaneous push/pop, then wrap the pointers
    force_done = 1'b1;
    push(8'd2, 8'd3, 16'd6);
    push(8'd4, 8'd5, 16'd20);
    chk("pp_fill_before", 32'(Fill), 2);
    force_done = 1'b0;
    push(8'd6, 8'd6, 16'd36);
    chk("pp_fill_same", 32'(Fill), 2);
    chk("pp_busy", 32'(Busy), 1);
    foreach (wrap_v[i]) push(wrap_v[i].a, wrap_v[i].b, wrap_v[i].p);
    wait_drain();

    // Backpressure
    Out_Ready = 1'b0;
    push(8'd3, 8'd5, 16'd15);
    push(8'd6, 8'd7, 16'd42);
    wait_out_valid();
    repeat (40) @(negedge Clock);
    chk("bp_valid_held", 32'(Out_Valid), 1);
    chk("bp_product_held", 32'(Out_Product), 15);
    chk("bp_start_stalled", 32'(Mul_Start), 1);
    chk("bp_done_held", 32'(Mul_Done), 1);
    chk("bp_fill", 32'(Fill), 0);
    @(posedge Clock); #1;
    Out_Ready = 1'b1;
    wait_drain();

    // Reset mid-op
    push(8'd9, 8'd9, 16'd81);
    push(8'd8, 8'd8, 16'd64);
    push(8'd7, 8'd7, 16'd49);
    push(8'd6, 8'd6, 16'd36);
    chk("mid_fill3", 32'(Fill), 3);
    chk("mid_in_issue", 32'(Mul_Start), 1);
    #2;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_start", 32'(Mul_Start), 0);
    chk("mid_rst_out_valid", 32'(Out_Valid), 0);
    chk("mid_rst_fill", 32'(Fill), 0);
    chk("mid_rst_in_ready", 32'(In_Ready), 1);
    repeat (2) begin @(posedge Clock); #1; end
    Reset_n = 1'b1;
    base = n_out;
    push(8'd7, 8'd9, 16'd63);
    wait_drain();
    chk("post_rst_count", 32'(n_out - base), 1);

    // Stale Done after reset
    Reset_n = 1'b0;
    force_done = 1'b1;
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    push(8'd5, 8'd5, 16'd25);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("stale_start_low", 32'(Mul_Start), 0);
    end
    chk("stale_fill", 32'(Fill), 1);
    @(posedge Clock); #1;
    force_done = 1'b0;
    @(posedge Clock); #1;
    chk("stale_then_issue", 32'(Mul_Start), 1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
